// File: rtl/fifo_flops_param_pkg.sv
// Shared helpers for fifo_flops_param: count-width sizing and parameter legality.
package fifo_flops_param_pkg;

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit params_legal(input int width, input int depth,
                                      input int af_thresh, input int ae_thresh);
    return (width >= 1) && (depth >= 2) &&
           (af_thresh >= 1) && (af_thresh <= depth) &&
           (ae_thresh >= 0) && (ae_thresh <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_ptr_wrap.sv
// FIFO pointer register: increments on demand, wraps at Depth-1, synchronous clear.
module fifo_ptr_wrap
  import fifo_flops_param_pkg::*;
#(
  parameter int Depth    = 8,
  parameter int PtrWidth = $clog2(Depth)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                incr,
  output logic [PtrWidth-1:0] ptr
);

  // Wrap by compare so non-power-of-two depths stay inside the storage array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (clear) begin
      ptr <= '0;
    end else if (incr) begin
      ptr <= (ptr == PtrWidth'(Depth - 1)) ? '0 : ptr + PtrWidth'(1);
    end
  end

endmodule

// File: rtl/fifo_flops_param.sv
// Parametrised flop-based FIFO with flush, registered threshold flags and
// optional zero-latency bypass enabled by FIFO_FLOPS_PARAM_BYPASS_EN.
module fifo_flops_param
  import fifo_flops_param_pkg::*;
#(
  parameter int Width                = 8,
  parameter int Depth                = 8,
  parameter int AlmostFullThreshold  = Depth - 1,
  parameter int AlmostEmptyThreshold = 1,
  localparam int CountWidth          = count_width(Depth)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [Width-1:0]      push_data,
  output logic                  pop_valid,
  input  logic                  pop_ready,
  output logic [Width-1:0]      pop_data,
  output logic                  full,
  output logic                  empty,
  output logic                  full_next,
  output logic                  empty_next,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CountWidth-1:0] items,
  output logic [CountWidth-1:0] slots,
  output logic [CountWidth-1:0] items_next,
  output logic [CountWidth-1:0] slots_next
);

  localparam int PtrWidth = $clog2(Depth);

  if (!params_legal(Width, Depth, AlmostFullThreshold, AlmostEmptyThreshold)) begin : g_bad_params
    $error("fifo_flops_param: illegal Width/Depth/threshold parameters");
  end

  logic [Width-1:0]    mem [Depth];
  logic [PtrWidth-1:0] wr_ptr;
  logic [PtrWidth-1:0] rd_ptr;
  logic                push_beat;
  logic                pop_beat;
  logic                store;
  logic                pop_ram;
  logic                almost_full_next;
  logic                almost_empty_next;

  assign push_ready = !full && !flush;
  assign push_beat  = push_valid && push_ready;
  assign pop_beat   = pop_valid && pop_ready;

`ifdef FIFO_FLOPS_PARAM_BYPASS_EN
  // An empty FIFO hands the incoming word straight to the consumer when it is ready.
  assign pop_valid = !flush && (!empty || push_valid);
  assign pop_data  = empty ? push_data : mem[rd_ptr];
  assign store     = push_beat && !(empty && pop_ready);
`else
  assign pop_valid = !flush && !empty;
  assign pop_data  = mem[rd_ptr];
  assign store     = push_beat;
`endif

  assign pop_ram = pop_beat && !empty;

  always_comb begin
    items_next = items;
    if (flush) begin
      items_next = '0;
    end else if (store && !pop_ram) begin
      items_next = items + CountWidth'(1);
    end else if (!store && pop_ram) begin
      items_next = items - CountWidth'(1);
    end
  end

  assign slots_next        = CountWidth'(Depth) - items_next;
  assign full_next         = (items_next == CountWidth'(Depth));
  assign empty_next        = (items_next == '0);
  assign almost_full_next  = (items_next >= CountWidth'(AlmostFullThreshold));
  assign almost_empty_next = (items_next <= CountWidth'(AlmostEmptyThreshold));

  fifo_ptr_wrap #(.Depth(Depth), .PtrWidth(PtrWidth)) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .incr  (store),
    .ptr   (wr_ptr)
  );

  fifo_ptr_wrap #(.Depth(Depth), .PtrWidth(PtrWidth)) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .incr  (pop_ram),
    .ptr   (rd_ptr)
  );

  // Storage is deliberately left unreset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (store) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      items        <= '0;
      slots        <= CountWidth'(Depth);
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      items        <= items_next;
      slots        <= slots_next;
      full         <= full_next;
      empty        <= empty_next;
      almost_full  <= almost_full_next;
      almost_empty <= almost_empty_next;
    end
  end

endmodule

// File: tb/tb_fifo_flops_param.sv
// Self-checking bench for fifo_flops_param (Depth=5): vector table, corner sequences, random vs queue model.
module tb_fifo_flops_param;

  localparam int Width      = 8;
  localparam int Depth      = 5;
  localparam int CountWidth = $clog2(Depth + 1);
`ifdef FIFO_FLOPS_PARAM_BYPASS_EN
  localparam bit BypassOn = 1'b1;
`else
  localparam bit BypassOn = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  flush;
  logic                  push_valid;
  logic                  push_ready;
  logic [Width-1:0]      push_data;
  logic                  pop_valid;
  logic                  pop_ready;
  logic [Width-1:0]      pop_data;
  logic                  full, empty, full_next, empty_next;
  logic                  almost_full, almost_empty;
  logic [CountWidth-1:0] items, slots, items_next, slots_next;

  int checks   = 0;
  int failures = 0;

  logic [Width-1:0] model_q[$];

  typedef struct {
    logic       flush;
    logic       push_valid;
    logic [7:0] push_data;
    logic       pop_ready;
    int         exp_items;
    logic       exp_push_ready;
    logic       chk_data;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  fifo_flops_param #(
    .Width(Width), .Depth(Depth), .AlmostFullThreshold(4), .AlmostEmptyThreshold(1)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
    .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
    .full(full), .empty(empty), .full_next(full_next), .empty_next(empty_next),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .items(items), .slots(slots), .items_next(items_next), .slots_next(slots_next)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compares every output against the queue model for the inputs currently applied.
  task automatic compareModel(input logic fl, input logic pv, input logic [7:0] pd, input logic pr,
                              output logic pa, output logic pb);
    int n, nn;
    logic epr, epv;
    n   = model_q.size();
    epr = (n < Depth) && !fl;
    epv = !fl && ((n > 0) || (BypassOn && pv));
    pa  = pv && epr;
    pb  = epv && pr;
    nn  = fl ? 0 : n + int'(pa) - int'(pb);
    checkOutput("push_ready", push_ready, epr);
    checkOutput("pop_valid", pop_valid, epv);
    if (epv) checkOutput("pop_data", pop_data, (n > 0) ? model_q[0] : pd);
    checkOutput("full", full, n == Depth);
    checkOutput("empty", empty, n == 0);
    checkOutput("almost_full", almost_full, n >= 4);
    checkOutput("almost_empty", almost_empty, n <= 1);
    checkOutput("items", items, n);
    checkOutput("slots", slots, Depth - n);
    checkOutput("items_next", items_next, nn);
    checkOutput("slots_next", slots_next, Depth - nn);
    checkOutput("full_next", full_next, nn == Depth);
    checkOutput("empty_next", empty_next, nn == 0);
  endtask

  task automatic applyStimulus(input logic fl, input logic pv, input logic [7:0] pd, input logic pr,
                               output logic seen_pr, output logic seen_pv, output logic [7:0] seen_pd);
    int n;
    logic pa, pb;
    flush = fl; push_valid = pv; push_data = pd; pop_ready = pr;
    #2;
    seen_pr = push_ready; seen_pv = pop_valid; seen_pd = pop_data;
    n = model_q.size();
    compareModel(fl, pv, pd, pr, pa, pb);
    @(posedge clk);
    if (fl) begin
      model_q.delete();
    end else begin
      if (pb && n > 0) void'(model_q.pop_front());
      if (pa && !(n == 0 && pb)) model_q.push_back(pd);
    end
    @(negedge clk);
  endtask

  task automatic step(input logic fl, input logic pv, input logic [7:0] pd, input logic pr);
    logic a, b;
    logic [7:0] c;
    applyStimulus(fl, pv, pd, pr, a, b, c);
  endtask

  initial begin
    logic sp, sv, pa, pb;
    logic [7:0] sd;

    rst = 1'b1; flush = 1'b0; push_valid = 1'b0; push_data = '0; pop_ready = 1'b0;
    #3;
    compareModel(1'b0, 1'b0, 8'h00, 1'b0, pa, pb);
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset in the middle of a stream.
    step(1'b0, 1'b1, 8'h21, 1'b0);
    step(1'b0, 1'b1, 8'h22, 1'b0);
    step(1'b0, 1'b1, 8'h23, 1'b1);
    push_valid = 1'b0; pop_ready = 1'b0;
    #2 rst = 1'b1;
    #1 model_q.delete();
    checkOutput("rst_items", items, 0);
    checkOutput("rst_slots", slots, Depth);
    compareModel(1'b0, 1'b0, 8'h00, 1'b0, pa, pb);
    @(negedge clk);
    rst = 1'b0;

    // Fill three then flush.
    step(1'b0, 1'b1, 8'h31, 1'b0);
    step(1'b0, 1'b1, 8'h32, 1'b0);
    step(1'b0, 1'b1, 8'h33, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h34, 1'b1, sp, sv, sd);
    checkOutput("flush_push_ready", sp, 0);
    checkOutput("flush_pop_valid", sv, 0);
    checkOutput("flush_items", items, 0);
    checkOutput("flush_empty", empty, 1);

    // Fill, wrap, simultaneous push/pop and full-with-pop.
    vecs.push_back('{1'b0, 1'b1, 8'h11, 1'b0, 0, 1'b1, 1'b0, 8'h00});
    vecs.push_back('{1'b0, 1'b1, 8'h12, 1'b0, 1, 1'b1, 1'b1, 8'h11});
    vecs.push_back('{1'b0, 1'b1, 8'h13, 1'b0, 2, 1'b1, 1'b1, 8'h11});
    vecs.push_back('{1'b0, 1'b1, 8'h14, 1'b0, 3, 1'b1, 1'b1, 8'h11});
    vecs.push_back('{1'b0, 1'b1, 8'h15, 1'b0, 4, 1'b1, 1'b1, 8'h11});
    vecs.push_back('{1'b0, 1'b1, 8'h99, 1'b0, 5, 1'b0, 1'b1, 8'h11});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 5, 1'b0, 1'b1, 8'h11});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 4, 1'b1, 1'b1, 8'h12});
    vecs.push_back('{1'b0, 1'b1, 8'h16, 1'b0, 3, 1'b1, 1'b1, 8'h13});
    vecs.push_back('{1'b0, 1'b1, 8'h17, 1'b0, 4, 1'b1, 1'b1, 8'h13});
    vecs.push_back('{1'b0, 1'b1, 8'hEE, 1'b1, 5, 1'b0, 1'b1, 8'h13});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 4, 1'b1, 1'b1, 8'h14});
    vecs.push_back('{1'b0, 1'b1, 8'h18, 1'b1, 3, 1'b1, 1'b1, 8'h15});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 3, 1'b1, 1'b1, 8'h16});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 2, 1'b1, 1'b1, 8'h17});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1, 1'b1, 1'b1, 8'h18});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b1, 1'b0, 8'h00});
    foreach (vecs[i]) begin
      checkOutput($sformatf("tbl%0d_items", i), items, vecs[i].exp_items);
      applyStimulus(vecs[i].flush, vecs[i].push_valid, vecs[i].push_data, vecs[i].pop_ready, sp, sv, sd);
      checkOutput($sformatf("tbl%0d_push_ready", i), sp, vecs[i].exp_push_ready);
      if (vecs[i].chk_data) checkOutput($sformatf("tbl%0d_pop_data", i), sd, vecs[i].exp_data);
    end

    // Threshold flags around their boundaries.
    step(1'b0, 1'b1, 8'h41, 1'b0);
    checkOutput("thr1_almost_empty", almost_empty, 1);
    step(1'b0, 1'b1, 8'h42, 1'b0);
    checkOutput("thr2_almost_empty", almost_empty, 0);
    step(1'b0, 1'b1, 8'h43, 1'b0);
    checkOutput("thr3_almost_full", almost_full, 0);
    step(1'b0, 1'b1, 8'h44, 1'b0);
    checkOutput("thr4_almost_full", almost_full, 1);
    step(1'b1, 1'b0, 8'h00, 1'b0);

    // Push into an empty FIFO with the consumer ready.
    applyStimulus(1'b0, 1'b1, 8'hA5, 1'b1, sp, sv, sd);
`ifdef FIFO_FLOPS_PARAM_BYPASS_EN
    checkOutput("byp_pop_valid", sv, 1);
    checkOutput("byp_pop_data", sd, 8'hA5);
    checkOutput("byp_items", items, 0);
`else
    checkOutput("nobyp_pop_valid", sv, 0);
    checkOutput("nobyp_items1", items, 1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, sp, sv, sd);
    checkOutput("nobyp_pop_valid_late", sv, 1);
    checkOutput("nobyp_pop_data", sd, 8'hA5);
    checkOutput("nobyp_items0", items, 0);
`endif

    // Randomised traffic with a varying push/pop bias.
    for (int i = 0; i < 600; i++) begin
      int bias;
      bias = (i / 100) % 3;
      step($urandom_range(0, 39) == 0,
           $urandom_range(0, 3) >= ((bias == 0) ? 1 : (bias == 1) ? 2 : 3),
           8'($urandom),
           $urandom_range(0, 3) >= ((bias == 0) ? 3 : (bias == 1) ? 2 : 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_flops_param.md
# fifo_flops_param

Parametrised flop-based FIFO: the next generation of the single-configuration FIFO, generalised in `Width` and `Depth` (including non-power-of-two depths). It adds a synchronous `flush`, registered almost-full/almost-empty flags, and an optional zero-cycle push→pop bypass. It sits between a valid/ready producer and consumer wherever a small shallow buffer is needed. Storage is a flop array with a combinational read port.

## Interface
- `Width`, 8, data bits per entry (≥1)
- `Depth`, 8, number of entries (≥2; need not be a power of two)
- `AlmostFullThreshold`, `Depth-1`, `almost_full` asserts when items ≥ this value (1..Depth)
- `AlmostEmptyThreshold`, 1, `almost_empty` asserts when items ≤ this value (0..Depth-1)
- `CountWidth` (localparam) = $clog2(Depth+1)

Ports:
- `clk` in 1: the single clock, rising edge
- `rst` in 1: reset, asynchronous and active-high
- `flush` in 1: synchronous clear
- `push_valid` in 1, `push_ready` out 1, `push_data` in Width: push handshake
- `pop_valid` out 1, `pop_ready` in 1, `pop_data` out Width: pop handshake
- `full`, `empty` out 1: registered status flags
- `full_next`, `empty_next` out 1: combinational next-state values of the flags
- `almost_full`, `almost_empty` out 1: registered threshold flags
- `items`, `slots` out CountWidth: registered occupancy; `slots` = Depth − `items`
- `items_next`, `slots_next` out CountWidth: combinational next-state values

## Operation
- `push_ready` = !full && !flush. It never depends on `pop_ready`, so a full FIFO refuses pushes even when a pop occurs in the same cycle.
- Push beat = push_valid && push_ready. Pop beat = pop_valid && pop_ready.
- A non-bypass push writes `mem[wr_ptr]` and advances `wr_ptr`. A pop advances `rd_ptr`.
- Pointers wrap from Depth−1 to 0 by compare, not by modulo-2^n.
- `pop_data` = `mem[rd_ptr]` when not empty.
- items_next = items + push_beat_stored − pop_beat_from_ram.
  - Simultaneous stored push and pop: items unchanged, both pointers advance.
- `full_next` = (items_next == Depth). `empty_next` = (items_next == 0).
- Flag registers load their `_next` values every cycle.
- Flush has priority over all other events:
  - At the edge where `flush`=1: pointers and items go to 0, empty=1, full=0, almost_empty=1, almost_full=0.
  - `push_ready`=0 and `pop_valid`=0 during the flush cycle. No write occurs.
- Reset (asynchronous, any time including mid-transfer) forces the same state as flush. The mem contents are not reset.
- Reset values of outputs:
  - push_ready=1, pop_valid=0, full=0, empty=1, almost_full=0, almost_empty=1, items=0, slots=Depth.
  - `pop_data` holds the bypassed `push_data` with bypass, and is don't-care without it.

## Timing
- The flag and count outputs are registered and update on the edge after the beat that changes them.
- The `_next` outputs are combinational from the current inputs.
- Latency without bypass: data pushed at edge N is visible on `pop_valid`/`pop_data` in cycle N+1.
- Throughput: one push and one pop per cycle in steady state.
- Back-to-back: a full FIFO popped at edge N shows `push_ready`=1 in cycle N+1.

## Configuration
- Macro: `FIFO_FLOPS_PARAM_BYPASS_EN`.
- Defined:
  - `pop_valid` = !flush && (!empty || push_valid).
  - When empty, `pop_data` = `push_data` combinationally.
  - If empty, push_valid and pop_ready are all 1, the beat bypasses the storage: no write, pointers and items unchanged. Latency is 0 cycles.
  - If empty, push_valid=1 and pop_ready=0, the data is written normally.
- Undefined: `pop_valid` = !flush && !empty. There is no combinational path from push to pop, and minimum latency is 1 cycle.

## Structure
- Package `fifo_flops_param_pkg` holds:
  - the count-width function (`$clog2(Depth+1)` helper);
  - the parameter legality checks as elaboration-time assertions: Depth≥2, thresholds in range.
- One sub-module: `fifo_ptr_wrap`, a pointer register with increment, wrap at Depth−1, and synchronous clear. It is instantiated twice (read and write pointers).
- Storage and flag logic stay in the top module.

## Test plan
- Reset and flush state: assert `rst` mid-stream with Depth=5 → all outputs take their reset values. Then fill 3 entries and pulse `flush` → items=0, empty=1 next cycle, no data popped.
- Fill and wrap: Depth=5 (non-power-of-two):
  - push 0x11..0x15 with pop_ready=0 → full=1, items=5, slots=0, push_ready=0;
  - pop 2, push 0x16, 0x17 → pointers wrap; pops then return 0x13..0x17 in order.
- Simultaneous push/pop at items=3 → items stays 3, data order preserved. At full with pop_ready=1 and push_valid=1 → pop only, items 5→4.
- Thresholds: AlmostFullThreshold=4, AlmostEmptyThreshold=1 → almost_full rises on the edge after the 4th push. almost_empty falls when items goes 1→2.
- Bypass (macro defined): empty FIFO, push_valid=1 with 0xA5, pop_ready=1 → pop_valid=1 and pop_data=0xA5 in the same cycle; items stays 0.
- Bypass (macro undefined): the same stimulus → pop_valid=0 that cycle, then 0xA5 is popped one cycle later; items goes 0→1→0.
